systolic_feeder: RTL

- Upstream stage of systolic_array; drives its load_weight, weight_in and feature_in ports directly.
- Accepts weight rows and unskewed feature vectors over valid/ready handshakes.
- Sequences the M_SIZE-cycle weight load, then diagonally skews features: lane c delayed c cycles, zero-filled.
- Guards weight reloads so they happen only on feature-matrix boundaries and only after the array has drained.

---
 rtl/systolic_feeder.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/systolic_feeder.sv
// Front end for systolic_array: sequences weight-row loads and diagonally skews
// feature vectors, draining the array before any weight reload.
module systolic_feeder #(
    parameter int WIDTH        = 32,
    parameter int M_SIZE       = 16,
    parameter int DRAIN_CYCLES = 2 * M_SIZE - 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      w_valid,
    output logic                      w_ready,
    input  logic [WIDTH*M_SIZE-1:0]   w_row,
    input  logic                      f_valid,
    output logic                      f_ready,
    input  logic [WIDTH*M_SIZE-1:0]   f_vec,
    output logic                      load_weight,
    output logic [WIDTH*M_SIZE-1:0]   weight_out,
    output logic [WIDTH*M_SIZE-1:0]   feature_out,
    output logic                      busy
);

    localparam int DRAIN_EFF = (DRAIN_CYCLES < 1) ? 1 : DRAIN_CYCLES;
    localparam int CW        = (M_SIZE > 1) ? $clog2(M_SIZE) : 1;
    localparam int DW        = (DRAIN_EFF > 1) ? $clog2(DRAIN_EFF) : 1;
    localparam logic [CW-1:0] LAST_IDX   = CW'(M_SIZE - 1);
    localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_EFF - 1);

    typedef enum logic [1:0] {
        LOAD_W = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_e;

    state_e                    state_q, state_d;
    logic [CW-1:0]             row_cnt_q, row_cnt_d;
    logic [CW-1:0]             vec_cnt_q, vec_cnt_d;
    logic [DW-1:0]             drain_cnt_q, drain_cnt_d;
    logic                      load_weight_q;
    logic [WIDTH*M_SIZE-1:0]   weight_out_q;
    logic                      w_ready_s, f_ready_s, w_hs_s, f_hs_s;
    logic [M_SIZE-1:0]         lane_nz_s;

    // Next-state, counter and handshake decode.
    always_comb begin
        state_d     = state_q;
        row_cnt_d   = row_cnt_q;
        vec_cnt_d   = vec_cnt_q;
        drain_cnt_d = drain_cnt_q;
        w_ready_s   = 1'b0;
        f_ready_s   = 1'b0;
        w_hs_s      = 1'b0;
        f_hs_s      = 1'b0;
        case (state_q)
            LOAD_W: begin
                w_ready_s = 1'b1;
                if (w_valid) begin
                    w_hs_s = 1'b1;
                    if (row_cnt_q == LAST_IDX) begin
                        row_cnt_d = {CW{1'b0}};
                        state_d   = STREAM;
                    end else begin
                        row_cnt_d = row_cnt_q + CW'(1);
                    end
                end else begin
                    w_hs_s = 1'b0;
                end
            end
            STREAM: begin
                // A pending reload only wins on a matrix boundary.
                f_ready_s = !(w_valid && (vec_cnt_q == {CW{1'b0}}));
                if (w_valid && (vec_cnt_q == {CW{1'b0}})) begin
                    state_d     = DRAIN;
                    drain_cnt_d = DRAIN_INIT;
                end else if (f_valid) begin
                    f_hs_s    = 1'b1;
                    vec_cnt_d = (vec_cnt_q == LAST_IDX) ? {CW{1'b0}} : vec_cnt_q + CW'(1);
                end else begin
                    f_hs_s = 1'b0;
                end
            end
            DRAIN: begin
                if (drain_cnt_q == {DW{1'b0}}) begin
                    state_d = LOAD_W;
                end else begin
                    drain_cnt_d = drain_cnt_q - DW'(1);
                end
            end
            default: begin
                state_d = LOAD_W;
            end
        endcase
    end

    // Control state and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD_W;
            row_cnt_q   <= {CW{1'b0}};
            vec_cnt_q   <= {CW{1'b0}};
            drain_cnt_q <= {DW{1'b0}};
        end else begin
            state_q     <= state_d;
            row_cnt_q   <= row_cnt_d;
            vec_cnt_q   <= vec_cnt_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    // Registered weight path; weight_out holds across handshake gaps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_weight_q <= 1'b0;
            weight_out_q  <= {(WIDTH*M_SIZE){1'b0}};
        end else begin
            load_weight_q <= w_hs_s;
            if (w_hs_s) begin
                weight_out_q <= w_row;
            end
        end
    end

    genvar c;
    generate
        for (c = 0; c < M_SIZE; c++) begin : g_lane
            logic [WIDTH-1:0] chain_q [c+1];
            logic             nz_s;

            // Lane c delay line, c+1 registers deep; bubbles enter as zero.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int d = 0; d <= c; d++) begin
                        chain_q[d] <= {WIDTH{1'b0}};
                    end
                end else begin
                    chain_q[0] <= f_hs_s ? f_vec[c*WIDTH +: WIDTH] : {WIDTH{1'b0}};
                    for (int d = 1; d <= c; d++) begin
                        chain_q[d] <= chain_q[d-1];
                    end
                end
            end

            // Any nonzero data still in flight on this lane.
            always_comb begin
                nz_s = 1'b0;
                for (int d = 0; d <= c; d++) begin
                    nz_s = nz_s | (|chain_q[d]);
                end
            end

            assign feature_out[c*WIDTH +: WIDTH] = chain_q[c];
            assign lane_nz_s[c]                  = nz_s;
        end
    endgenerate

    assign w_ready     = w_ready_s;
    assign f_ready     = f_ready_s;
    assign load_weight = load_weight_q;
    assign weight_out  = weight_out_q;
    assign busy        = (state_q == DRAIN) || ((state_q == STREAM) && (|lane_nz_s));

endmodule
